// File: rtl/led_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
// Holds default parameters, the index-width helper and the digit one-hot decoder.
package led_pkg;

    localparam int NDIGITS_DEF   = 4;
    localparam int SCAN_DIV_DEF  = 1000;
    localparam int BLANK_CYC_DEF = 8;
    localparam int MAX_DIGITS    = 32;

    // Bits needed to count 0..n-1; never less than 1 so a
    // single-digit build still has a legal index register.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] dig_onehot(input int idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/led_scan_tick.sv
// scan_tick: digit-slot prescaler, counts 0..DIV-1 and flags the last cycle.
// Ports: clk, rst_n (async active-low), cnt_o (slot cycle), tick_o (cnt_o==DIV-1).
module scan_tick
    import led_pkg::*;
#(
    parameter int DIV = SCAN_DIV_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [clog2_min1(DIV)-1:0] cnt_o,
    output logic                       tick_o
);

    localparam int             CW   = clog2_min1(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == LAST);
        cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/led_scan.sv
// led_scan: time-multiplexes a double-buffered hex value onto a 7-segment display.
// Ports: clk, rst_n (async active-low), value/load (shadow write), nibble (to ledout),
//        dig_sel (one-hot commons), frame_tick (last frame cycle), pending (shadow dirty).
// Build option: define LED_SCAN_LZB_EN for leading-zero blanking.
module led_scan
    import led_pkg::*;
#(
    parameter int NDIGITS   = NDIGITS_DEF,
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*NDIGITS-1:0] value,
    input  logic                 load,
    output logic [3:0]           nibble,
    output logic [NDIGITS-1:0]   dig_sel,
    output logic                 frame_tick,
    output logic                 pending
);

    localparam int               CW       = clog2_min1(SCAN_DIV);
    localparam int               IW       = clog2_min1(NDIGITS);
    localparam logic [IW-1:0]    IDX_LAST = IW'(NDIGITS - 1);

    logic [CW-1:0]        cnt;
    logic                 tick;

    logic [IW-1:0]        idx_q,     idx_d;
    logic [4*NDIGITS-1:0] shadow_q,  shadow_d;
    logic [4*NDIGITS-1:0] active_q,  active_d;
    logic                 pending_q, pending_d;

    logic                 blank;
    logic [NDIGITS-1:0]   show_mask;

    scan_tick #(
        .DIV    (SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt_o  (cnt),
        .tick_o (tick)
    );

    assign frame_tick = tick && (idx_q == IDX_LAST);

    always_comb begin
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        // Commit uses the pre-edge shadow, so a coincident load
        // lands in the shadow and stays pending for the next frame.
        if (frame_tick && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (int'(cnt) < BLANK_CYC);
        end
    endgenerate

`ifdef LED_SCAN_LZB_EN
    // A digit is lit if it or any more-significant digit is nonzero;
    // digit 0 always shows so zero still reads as "0".
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_mask
            if (gi == 0) begin : g_d0
                assign show_mask[gi] = 1'b1;
            end else begin : g_dn
                assign show_mask[gi] = |active_q[4*NDIGITS-1:4*gi];
            end
        end
    endgenerate
`else
    assign show_mask = '1;
`endif

    assign nibble  = active_q[{idx_q, 2'b00} +: 4];
    assign dig_sel = blank ? '0
                   : (NDIGITS'(dig_onehot(int'(idx_q))) & show_mask);
    assign pending = pending_q;

endmodule
